// File: rtl/multicycle_control.sv
// multicycle_control: Moore main-control FSM for the multi-cycle MIPS datapath (R, lw, sw, beq, ori, lui, j).
// Optional feature macro MC_CTRL_JAL_EN: adds jal (op 000011) and widens RegDst/MemtoReg to 2 bits.
// Strobes are registered from the next state; only the FETCH IR/PC write is qualified live by mem_ready.
module multicycle_control #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSrc,
`ifdef MC_CTRL_JAL_EN
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
`else
  output logic             RegDst,
  output logic             MemtoReg,
`endif
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALU_op,
  output logic             R_type,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

`ifdef MC_CTRL_JAL_EN
  localparam int SEL_W = 2;
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(6'b000011);
`else
  localparam int SEL_W = 1;
`endif

  // Wait counter only needs to reach TIMEOUT-1; the TIMEOUT-th idle cycle traps.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ORI = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LUI = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_TRAP
  } state_t;

  // One registered control word; 'fetch' marks the FETCH state so the IR/PC
  // load can be gated by the memory completing in that very cycle.
  typedef struct packed {
    logic             mem_req;
    logic             iord;
    logic             fetch;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic [SEL_W-1:0] reg_dst;
    logic [SEL_W-1:0] mem_to_reg;
    logic             reg_write;
    logic             mem_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             r_type;
  } ctrl_t;

  state_t            state;
  state_t            state_nxt;
  ctrl_t             ctrl;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait;
  logic              wait_last;
  logic              timeout_hit;
  logic              retire;
  logic              fetch_done;

  // The ALU zero flag gates PCWriteCond in the datapath, not in the sequencer.
  logic unused_zero;
  assign unused_zero = zero;

  // Successor state from current state, opcode and memory handshake.
  function automatic state_t next_state(input state_t s, input logic [OP_W-1:0] o,
                                        input logic rdy, input logic last);
    state_t n;
    n = s;
    case (s)
      S_RST:    n = S_FETCH;
      S_FETCH: begin
        if (rdy)       n = S_DECODE;
        else if (last) n = S_TRAP;
      end
      S_DECODE: begin
        if (o == OP_R)                      n = S_EXEC_R;
        else if (o == OP_LW || o == OP_SW)  n = S_MEM_ADDR;
        else if (o == OP_BEQ)               n = S_BRANCH;
        else if (o == OP_ORI || o == OP_LUI) n = S_EXEC_I;
        else if (o == OP_J)                 n = S_JUMP;
`ifdef MC_CTRL_JAL_EN
        else if (o == OP_JAL)               n = S_JAL;
`endif
        else                                n = S_TRAP;
      end
      S_EXEC_R:   n = S_WB_R;
      S_EXEC_I:   n = S_WB_I;
      S_MEM_ADDR: n = (o == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (rdy)       n = S_WB_MEM;
        else if (last) n = S_TRAP;
      end
      S_MEM_WR: begin
        if (rdy)       n = S_FETCH;
        else if (last) n = S_TRAP;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL: n = S_FETCH;
      S_TRAP:   n = S_TRAP;
      default:  n = S_RST;
    endcase
    return n;
  endfunction

  // Datapath strobes asserted while sitting in a given state.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OP_W-1:0] o);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch     = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.r_type    = 1'b1;
      end
      S_WB_R: begin
        c.reg_dst   = SEL_W'(1);
        c.reg_write = 1'b1;
        c.r_type    = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (o == OP_ORI) ? 3'b010 : 3'b110;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_WB_MEM: begin
        c.mem_to_reg = SEL_W'(1);
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b100;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_src     = 2'b10;
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  assign mem_wait    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign wait_last   = (wait_cnt == WAIT_LAST);
  assign timeout_hit = mem_wait && !mem_ready && wait_last;
  assign state_nxt   = next_state(state, op, mem_ready, wait_last);
  assign retire      = (state_nxt == S_FETCH) &&
                       (state inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL});

  // State register, next-state strobes, wait counter, sticky fault and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST;
      ctrl     <= '0;
      wait_cnt <= '0;
      fault    <= 2'b00;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode_ctrl(state_nxt, op);
      // Only a stalled memory state keeps counting; any entry or exit restarts it.
      if (mem_wait && state_nxt == state) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                wait_cnt <= '0;
      if (state_nxt == S_TRAP && state != S_TRAP)
        fault <= timeout_hit ? 2'b10 : 2'b01;
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  // IR and PC load exactly in the cycle the instruction word arrives.
  assign fetch_done  = ctrl.fetch & mem_ready & ~rst;

  assign mem_req     = ctrl.mem_req;
  assign IorD        = ctrl.iord;
  assign IRWrite     = fetch_done;
  assign PCWrite     = ctrl.pc_write | fetch_done;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSrc       = ctrl.pc_src;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign MemWrite    = ctrl.mem_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALU_op      = ctrl.alu_op;
  assign R_type      = ctrl.r_type;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream against a per-instruction control-word model.
// Each instruction expands into its expected cycle-by-cycle control words from the opcode and memory waits.
// Clocked 10 ns; inputs driven on the falling edge, outputs sampled 1 ns later.
`timescale 1ns/1ps
module tb_multicycle_control;
  localparam int TO = 4;
  localparam int CW = 4;
`ifdef MC_CTRL_JAL_EN
  localparam int SW = 2;
`else
  localparam int SW = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic [5:0]    op = 6'd0;
  logic          mem_req, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite, ALUSrcA, R_type;
  logic [1:0]    PCSrc, ALUSrcB, fault;
  logic [2:0]    ALU_op;
  logic [SW-1:0] RegDst, MemtoReg;
  logic [CW-1:0] retired;

  multicycle_control #(.OP_W(6), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_op(ALU_op), .R_type(R_type), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mem_req;
    logic          iord;
    logic          ir_write;
    logic          pc_write;
    logic          pc_write_cond;
    logic [1:0]    pc_src;
    logic [SW-1:0] reg_dst;
    logic [SW-1:0] mem_to_reg;
    logic          reg_write;
    logic          mem_write;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic          r_type;
  } ctrl_t;

  ctrl_t act;
  assign act = {mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc, RegDst, MemtoReg,
                RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALU_op, R_type};

  int            n_chk = 0;
  int            n_fail = 0;
  logic [CW-1:0] retired_exp = '0;
  logic          rdy_q[$];
  ctrl_t         exp_q[$];
  string         ph_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, want);
    end
  endtask

  // Control word the datapath should see during one phase of an instruction.
  function automatic ctrl_t word(input string ph, input logic rdy, input logic [5:0] o);
    ctrl_t c = '0;
    case (ph)
      "FETCH":    begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      "DECODE":   c.alu_src_b = 2'b11;
      "EXEC_R":   begin c.alu_src_a = 1; c.r_type = 1; end
      "WB_R":     begin c.reg_dst = SW'(1); c.reg_write = 1; c.r_type = 1; end
      "EXEC_I":   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (o == 6'b001101) ? 3'b010 : 3'b110; end
      "WB_I":     c.reg_write = 1;
      "MEM_ADDR": begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      "MEM_RD":   begin c.mem_req = 1; c.iord = 1; end
      "WB_MEM":   begin c.mem_to_reg = SW'(1); c.reg_write = 1; end
      "MEM_WR":   begin c.mem_req = 1; c.iord = 1; c.mem_write = 1; end
      "BRANCH":   begin c.alu_src_a = 1; c.alu_op = 3'b100; c.pc_write_cond = 1; c.pc_src = 2'b01; end
      "JUMP":     begin c.pc_write = 1; c.pc_src = 2'b10; end
`ifdef MC_CTRL_JAL_EN
      "JAL":      begin c.pc_write = 1; c.pc_src = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  task automatic push_rdy(input string ph, input logic rdy, input logic [5:0] o);
    rdy_q.push_back(rdy);
    exp_q.push_back(word(ph, rdy, o));
    ph_q.push_back(ph);
  endtask

  // Non-memory phase: mem_ready is random noise there.
  task automatic push(input string ph, input logic [5:0] o);
    push_rdy(ph, 1'($urandom), o);
  endtask

  // Memory phase with w idle cycles; w >= TO means the bus times out.
  task automatic push_mem(input string ph, input int w, input logic [5:0] o, output bit to);
    to = (w >= TO);
    for (int k = 0; k < (to ? TO : w); k++) push_rdy(ph, 1'b0, o);
    if (!to) push_rdy(ph, 1'b1, o);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_ctrl", 32'(act), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    retired_exp = '0;
  endtask

  // Run one instruction; abort_at >= 0 stops after that cycle (caller resets).
  task automatic do_instr(input logic [5:0] o, input int fw, input int mw, input int abort_at);
    bit to;
    logic [1:0] trap;
    rdy_q.delete(); exp_q.delete(); ph_q.delete();
    trap = 2'b00;
    push_mem("FETCH", fw, o, to);
    if (to) trap = 2'b10;
    else begin
      push("DECODE", o);
      case (o)
        6'b000000: begin push("EXEC_R", o); push("WB_R", o); end
        6'b100011: begin
          push("MEM_ADDR", o); push_mem("MEM_RD", mw, o, to);
          if (to) trap = 2'b10; else push("WB_MEM", o);
        end
        6'b101011: begin push("MEM_ADDR", o); push_mem("MEM_WR", mw, o, to); if (to) trap = 2'b10; end
        6'b000100: push("BRANCH", o);
        6'b001101, 6'b001111: begin push("EXEC_I", o); push("WB_I", o); end
        6'b000010: push("JUMP", o);
`ifdef MC_CTRL_JAL_EN
        6'b000011: push("JAL", o);
`endif
        default: trap = 2'b01;
      endcase
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      op = o;
      mem_ready = rdy_q[i];
      zero = 1'($urandom);
      #1;
      check_eq(ph_q[i], 32'(act), 32'(exp_q[i]));
      check_eq("fault_run", 32'(fault), 32'd0);
      if (i == 0) check_eq("retired", 32'(retired), 32'(retired_exp));
      if (i == abort_at) return;
    end
    if (trap != 2'b00) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        mem_ready = 1'($urandom);
        #1;
        check_eq("trap_ctrl", 32'(act), 32'd0);
        check_eq("trap_fault", 32'(fault), 32'(trap));
        check_eq("trap_retired", 32'(retired), 32'(retired_exp));
      end
      reset_dut();
    end else begin
      retired_exp = retired_exp + CW'(1);
    end
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [10];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001101,
            6'b001111, 6'b000010, 6'b000011, 6'b111111, 6'b000000};
    reset_dut();
    do_instr(6'b000000, 0, 0, -1);        // R: 4 cycles, RegWrite only in writeback
    do_instr(6'b100011, 0, 3, -1);        // lw with 3 idle cycles: 8 cycles
    do_instr(6'b000100, 0, 0, -1);        // beq: 3 cycles
    do_instr(6'b001101, 1, 0, -1);        // ori
    do_instr(6'b001111, 2, 0, -1);        // lui
    do_instr(6'b000010, 0, 0, -1);        // j
    do_instr(6'b101011, TO - 1, TO - 1, -1); // ready on the last allowed cycle wins
    do_instr(6'b000000, TO, 0, -1);       // fetch timeout -> fault 10
    do_instr(6'b100011, 0, TO, -1);       // load timeout -> fault 10
    do_instr(6'b111111, 0, 0, -1);        // illegal op -> fault 01
    do_instr(6'b000011, 0, 0, -1);        // jal, or illegal when not built in
    do_instr(6'b101011, 0, 3, 4);         // reset while stalled in the store
    reset_dut();
    do_instr(6'b000000, 0, 0, -1);
    for (int n = 0; n < 18; n++)          // long enough to wrap the retire counter
      do_instr(ops[$urandom_range(0, 6)], 0, 0, -1);
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      do_instr(o, pick_wait(), pick_wait(), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
